imm_gen_stage: RTL and testbench

Registered, parametrised immediate-generation stage for the decode pipeline. It accepts an instruction word and its decoded inst_type over a valid/ready handshake, extracts and sign-/zero-extends the immediate to XLEN, and buffers results in a 2-entry skid FIFO. The FIFO decouples decode from register-read backpressure. Supports RV32 and RV64 shift-amount widths, the CSR zimm format, a sideband tag and a pipeline flush.

---
 rtl/imm_gen_stage.sv | 124 ++++++++++++
 tb/tb_imm_gen_stage.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// Immediate generator feeding a 2-entry FIFO: 1-cycle latency into an empty queue, 1 entry/cycle throughput.
// Backpressure: ready_o drops only when both entries are full (state-only, never from ready_i).
package imm_gen_pkg;
  typedef enum logic [2:0] {
    INST_R = 3'd0,
    INST_I = 3'd1,
    INST_S = 3'd2,
    INST_B = 3'd3,
    INST_U = 3'd4,
    INST_J = 3'd5,
    INST_Z = 3'd6
  } inst_type;
endpackage

module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [31:0]       instruction_i,
  input  inst_type          instruction_type_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [XLEN-1:0]   immediate_o,
  output inst_type          instruction_type_o,
  output logic [TAG_W-1:0]  tag_o
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  localparam logic SHAMT6 = (XLEN == 64);

  logic [XLEN-1:0]  imm_q  [2];
  inst_type         type_q [2];
  logic [TAG_W-1:0] tag_q  [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [XLEN-1:0]  imm_d;
  logic             enq;
  logic             deq;
  logic             unused_opcode;

  // Opcode bits carry no immediate content in any format.
  assign unused_opcode = ^instruction_i[6:0];

  always_comb begin
    imm_d = '0;
    case (instruction_type_i)
      INST_I: imm_d = {{(XLEN-12){instruction_i[31]}}, instruction_i[31:20]};
      INST_S: imm_d = {{(XLEN-12){instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
      INST_B: imm_d = {{(XLEN-13){instruction_i[31]}}, instruction_i[31], instruction_i[7],
                       instruction_i[30:25], instruction_i[11:8], 1'b0};
      INST_U: imm_d = {{(XLEN-31){instruction_i[31]}}, instruction_i[30:12], 12'b0};
      INST_J: imm_d = {{(XLEN-21){instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                       instruction_i[20], instruction_i[30:21], 1'b0};
      INST_R: imm_d = {{(XLEN-6){1'b0}}, SHAMT6 & instruction_i[25], instruction_i[24:20]};
      INST_Z: imm_d = {{(XLEN-5){1'b0}}, instruction_i[19:15]};
      default: imm_d = '0;
    endcase
  end

  assign ready_o = (count != 2'd2);
  assign valid_o = (count != 2'd0);
  assign enq     = valid_i && ready_o;
  assign deq     = valid_o && ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      imm_q[0]  <= '0;
      imm_q[1]  <= '0;
      type_q[0] <= INST_R;
      type_q[1] <= INST_R;
      tag_q[0]  <= '0;
      tag_q[1]  <= '0;
    end else if (flush_i) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (enq) begin
        imm_q[wr_ptr]  <= imm_d;
        type_q[wr_ptr] <= instruction_type_i;
        tag_q[wr_ptr]  <= tag_i;
        wr_ptr         <= ~wr_ptr;
      end
      if (deq) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign immediate_o        = imm_q[rd_ptr];
  assign instruction_type_o = type_q[rd_ptr];
  assign tag_o              = tag_q[rd_ptr];

  a_no_enq_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    enq |-> (count != 2'd2));

  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count <= 2'd2);

  a_head_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i && !flush_i) |=>
      ($stable(immediate_o) && $stable(instruction_type_o) && $stable(tag_o)));

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share one stimulus stream
// and are checked against a queue model with arithmetic immediate decoding.
module tb_imm_gen_stage;
  import imm_gen_pkg::*;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic        flush  = 1'b0;
  logic        vin    = 1'b0;
  logic        rdy_in = 1'b0;
  logic [31:0] instr  = '0;
  inst_type    itype  = INST_R;
  logic [7:0]  tag_in = '0;

  logic        rdy32, vout32, rdy64, vout64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  inst_type    ty32, ty64;
  logic [7:0]  tag32, tag64;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [31:0] i32;
    logic [63:0] i64;
    inst_type    t;
    logic [7:0]  tag;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(vin), .ready_o(rdy32),
    .instruction_i(instr), .instruction_type_i(itype), .tag_i(tag_in),
    .valid_o(vout32), .ready_i(rdy_in), .immediate_o(imm32),
    .instruction_type_o(ty32), .tag_o(tag32));

  imm_gen_stage #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(vin), .ready_o(rdy64),
    .instruction_i(instr), .instruction_type_i(itype), .tag_i(tag_in),
    .valid_o(vout64), .ready_i(rdy_in), .immediate_o(imm64),
    .instruction_type_o(ty64), .tag_o(tag64));

  // Immediate value as a signed integer, then wrapped to the requested width.
  function automatic logic [63:0] ref_imm(input logic [31:0] w, input inst_type t, input int xlen);
    longint v;
    case (t)
      INST_I: begin
        v = longint'(w[31:20]);
        if (v >= 2048) v = v - 4096;
      end
      INST_S: begin
        v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
        if (v >= 2048) v = v - 4096;
      end
      INST_B: begin
        v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
        if (v >= 4096) v = v - 8192;
      end
      INST_U: begin
        v = longint'(w[31:12]) * 4096;
        if (v >= 64'sd2147483648) v = v - 64'sd4294967296;
      end
      INST_J: begin
        v = longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
        if (v >= 1048576) v = v - 2097152;
      end
      INST_R:  v = (xlen == 32) ? longint'(w[24:20]) : longint'(w[25:20]);
      INST_Z:  v = longint'(w[19:15]);
      default: v = 0;
    endcase
    if (xlen == 32) return {32'h0, v[31:0]};
    return v;
  endfunction

  // One clock edge: the model applies the same handshake rules to its queue.
  task automatic tick();
    bit          m_ready;
    bit          m_valid;
    ent_t        e;
    logic [63:0] r;
    m_ready = (q.size() < 2);
    m_valid = (q.size() > 0);
    @(posedge clk);
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      if (m_valid && rdy_in) void'(q.pop_front());
      if (vin && m_ready) begin
        r     = ref_imm(instr, itype, 32);
        e.i32 = r[31:0];
        e.i64 = ref_imm(instr, itype, 64);
        e.t   = itype;
        e.tag = tag_in;
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    q.delete();
    #1;
    n_chk++;
    if ({vout32, rdy32, vout64, rdy64} !== 4'b0101)
      $display("FAIL reset_handshake: got v/r32 v/r64 %b want 0101", {vout32, rdy32, vout64, rdy64});
    else n_pass++;
    n_chk++;
    if (imm32 !== 32'h0 || imm64 !== 64'h0 || tag32 !== 8'h0 || tag64 !== 8'h0 || ty32 !== INST_R || ty64 !== INST_R)
      $display("FAIL reset_head: got imm %h/%h tag %h/%h type %0d/%0d want zeros and INST_R",
               imm32, imm64, tag32, tag64, ty32, ty64);
    else n_pass++;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    rdy_in = 1'b1;
    vin    = 1'b1;
    instr  = 32'hFFF00093;
    itype  = INST_I;
    tag_in = 8'h11;
    tick();
    vin = 1'b0;
    n_chk++;
    if ({vout32, vout64} !== 2'b11 || imm32 !== 32'hFFFFFFFF || imm64 !== 64'hFFFFFFFFFFFFFFFF || tag32 !== 8'h11 || tag64 !== 8'h11)
      $display("FAIL addi_head: got v %b imm %h/%h tag %h/%h want v 11 imm ffffffff/ffffffffffffffff tag 11",
               {vout32, vout64}, imm32, imm64, tag32, tag64);
    else n_pass++;
    tick();
    n_chk++;
    if ({vout32, rdy32, vout64, rdy64} !== 4'b0101)
      $display("FAIL addi_drain: got %b want 0101", {vout32, rdy32, vout64, rdy64});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ti  [8] = '{32'hFFF00093, 32'h800000B7, 32'h43F0D093, 32'hFE000EE3,
                             32'h340AD073, 32'hFE512A23, 32'h001000EF, 32'hFFFFFFFF};
    inst_type    tt  [8] = '{INST_I, INST_U, INST_R, INST_B, INST_Z, INST_S, INST_J, inst_type'(3'd7)};
    logic [31:0] e32 [8] = '{32'hFFFFFFFF, 32'h80000000, 32'h0000001F, 32'hFFFFFFFC,
                             32'h00000015, 32'hFFFFFFF4, 32'h00000800, 32'h00000000};
    logic [63:0] e64 [8] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 64'h000000000000003F,
                             64'hFFFFFFFFFFFFFFFC, 64'h0000000000000015, 64'hFFFFFFFFFFFFFFF4,
                             64'h0000000000000800, 64'h0000000000000000};
    logic [7:0] etag;
    rdy_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vin    = 1'b1;
      instr  = ti[i];
      itype  = tt[i];
      etag   = 8'h40 + 8'(i);
      tag_in = etag;
      tick();
      n_chk++;
      if ({vout32, vout64} !== 2'b11 || imm32 !== e32[i] || imm64 !== e64[i] || ty32 !== tt[i] || ty64 !== tt[i] || tag32 !== etag)
        $display("FAIL b2b_entry%0d: got v %b imm %h/%h type %0d/%0d tag %h want imm %h/%h type %0d tag %h",
                 i, {vout32, vout64}, imm32, imm64, ty32, ty64, tag32, e32[i], e64[i], tt[i], etag);
      else n_pass++;
    end
    vin = 1'b0;
    tick();
    n_chk++;
    if ({vout32, vout64} !== 2'b00)
      $display("FAIL b2b_drain: got valid %b want 00", {vout32, vout64});
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [63:0] r;
    logic [31:0] exp_imm;
    rdy_in = 1'b0;
    itype  = INST_I;
    instr  = $urandom();
    r      = ref_imm(instr, INST_I, 32);
    exp_imm = r[31:0];
    vin    = 1'b1;
    tag_in = 8'd1;
    tick();
    n_chk++;
    if ({vout32, rdy32} !== 2'b11 || tag32 !== 8'd1)
      $display("FAIL bp_first: got v/r %b tag %0d want 11 tag 1", {vout32, rdy32}, tag32);
    else n_pass++;
    tag_in = 8'd2;
    tick();
    n_chk++;
    if ({vout32, rdy32, vout64, rdy64} !== 4'b1010 || tag32 !== 8'd1)
      $display("FAIL bp_full: got v/r %b tag %0d want 1010 tag 1", {vout32, rdy32, vout64, rdy64}, tag32);
    else n_pass++;
    tag_in = 8'd3;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++;
      if (rdy32 !== 1'b0 || vout32 !== 1'b1 || tag32 !== 8'd1 || imm32 !== exp_imm || ty32 !== INST_I)
        $display("FAIL bp_stall%0d: got r %b v %b tag %0d imm %h want r 0 v 1 tag 1 imm %h",
                 k, rdy32, vout32, tag32, imm32, exp_imm);
      else n_pass++;
    end
    rdy_in = 1'b1;
    tick();
    n_chk++;
    if ({vout32, rdy32} !== 2'b11 || tag32 !== 8'd2 || tag64 !== 8'd2)
      $display("FAIL bp_out2: got v/r %b tag %0d/%0d want 11 tag 2", {vout32, rdy32}, tag32, tag64);
    else n_pass++;
    tick();
    vin = 1'b0;
    n_chk++;
    if (vout32 !== 1'b1 || tag32 !== 8'd3 || tag64 !== 8'd3)
      $display("FAIL bp_out3: got v %b tag %0d/%0d want v 1 tag 3", vout32, tag32, tag64);
    else n_pass++;
    tick();
    n_chk++;
    if ({vout32, vout64} !== 2'b00)
      $display("FAIL bp_drain: got valid %b want 00", {vout32, vout64});
    else n_pass++;
  endtask

  task automatic test_flush();
    rdy_in = 1'b0;
    vin    = 1'b1;
    itype  = INST_Z;
    instr  = $urandom();
    tag_in = 8'hA1;
    tick();
    tag_in = 8'hA2;
    tick();
    n_chk++;
    if ({vout32, rdy32} !== 2'b10)
      $display("FAIL flush_prefill: got v/r %b want 10", {vout32, rdy32});
    else n_pass++;
    flush  = 1'b1;
    tag_in = 8'hA3;
    tick();
    flush = 1'b0;
    vin   = 1'b0;
    n_chk++;
    if ({vout32, rdy32, vout64, rdy64} !== 4'b0101)
      $display("FAIL flush_clear: got %b want 0101", {vout32, rdy32, vout64, rdy64});
    else n_pass++;
    rdy_in = 1'b1;
    tick();
    tick();
    n_chk++;
    if ({vout32, rdy32, vout64, rdy64} !== 4'b0101)
      $display("FAIL flush_no_ghost: got %b want 0101", {vout32, rdy32, vout64, rdy64});
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [63:0] r;
    rdy_in = 1'b0;
    vin    = 1'b1;
    itype  = INST_S;
    instr  = $urandom();
    tag_in = 8'h5A;
    tick();
    vin = 1'b0;
    n_chk++;
    if ({vout32, rdy32} !== 2'b11)
      $display("FAIL arst_pre: got v/r %b want 11", {vout32, rdy32});
    else n_pass++;
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    n_chk++;
    if ({vout32, rdy32, vout64, rdy64} !== 4'b0101)
      $display("FAIL arst_immediate: got %b want 0101", {vout32, rdy32, vout64, rdy64});
    else n_pass++;
    tick();
    rst_n  = 1'b1;
    vin    = 1'b1;
    itype  = INST_J;
    instr  = $urandom();
    tag_in = 8'h6B;
    rdy_in = 1'b1;
    tick();
    vin = 1'b0;
    r   = ref_imm(instr, INST_J, 32);
    n_chk++;
    if (vout32 !== 1'b1 || tag32 !== 8'h6B || imm32 !== r[31:0] || imm64 !== ref_imm(instr, INST_J, 64))
      $display("FAIL arst_first_entry: got v %b tag %h imm %h want v 1 tag 6b imm %h", vout32, tag32, imm32, r[31:0]);
    else n_pass++;
    tick();
    n_chk++;
    if ({vout32, vout64} !== 2'b00)
      $display("FAIL arst_drain: got valid %b want 00", {vout32, vout64});
    else n_pass++;
  endtask

  task automatic test_random();
    logic exp_v;
    logic exp_r;
    for (int c = 0; c < 400; c++) begin
      vin    = ($urandom_range(0, 9) < 7);
      rdy_in = ($urandom_range(0, 9) < 6);
      flush  = ($urandom_range(0, 99) < 3);
      instr  = $urandom();
      itype  = inst_type'(3'($urandom_range(0, 7)));
      tag_in = 8'($urandom());
      tick();
      exp_v = (q.size() != 0);
      exp_r = (q.size() != 2);
      n_chk++;
      if ({vout32, rdy32, vout64, rdy64} !== {exp_v, exp_r, exp_v, exp_r})
        $display("FAIL rand_hs cycle %0d: got %b want %b", c, {vout32, rdy32, vout64, rdy64}, {exp_v, exp_r, exp_v, exp_r});
      else n_pass++;
      if (exp_v) begin
        n_chk++;
        if ({imm32, ty32, tag32, imm64, ty64, tag64} !== {q[0].i32, q[0].t, q[0].tag, q[0].i64, q[0].t, q[0].tag})
          $display("FAIL rand_head cycle %0d: got imm %h/%h type %0d/%0d tag %h/%h want imm %h/%h type %0d tag %h",
                   c, imm32, imm64, ty32, ty64, tag32, tag64, q[0].i32, q[0].i64, q[0].t, q[0].tag);
        else n_pass++;
      end
    end
    flush = 1'b0;
    vin   = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
